kd_node_ce: RTL and testbench
=============================

Name: kd_node_ce

Overview:
- Sequential, parametrised compare-exchange / nearest-centre element for one node of the kd-tree k-means engine.
- Replaces the fixed 3-D combinational node element: arbitrary dimension count and data width, a start/done handshake, and registered outputs.
- Two modes. Sort mode orders left/parent/right centres along the split axis. Search mode accumulates Manhattan distances one dimension per cycle, tracks the best centre and makes the branch/prune decision.

Parameters:
- DIM, 3, number of dimensions per point/centre (>=1).
- DATA_W, 8, bits per coordinate (unsigned).
- AXIS_W, $clog2(DIM) (min 1), width of axis select.
- DIST_W, DATA_W+$clog2(DIM), width of Manhattan distance; cannot overflow.
- name, "unknown", instance tag for simulation messages only.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  operation request; sampled only when busy=0
- mode  in  1  0=sort, 1=search
- left_en  in  1  left child slot valid (sort mode)
- right_en  in  1  right child slot valid (sort mode)
- returned  in  1  search mode: evaluate other-branch pruning
- axis  in  AXIS_W  split dimension; values >=DIM treated as 0
- left  in  DIM*DATA_W  sort: left centre; search: query point
- parent  in  DIM*DATA_W  sort: parent centre; search: node centre
- right  in  DIM*DATA_W  sort: right centre; search: current best centre
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result outputs valid from this cycle
- stable, left_switch, parent_switch, right_switch  out  1 each  sort result flags
- first_direction  out  1  1=descend left, 0=descend right
- other_branch  out  1  1=other subtree must also be searched
- new_left, new_parent, new_right  out  DIM*DATA_W each  result centres
- best_dist  out  DIST_W  search: winning distance

Behaviour:
- Coordinate i occupies bits [i*DATA_W +: DATA_W]. All arithmetic is unsigned. |a-b| is computed as (a>=b)?a-b:b-a. No sign-bit tricks.
- Reset: FSM to IDLE. Accumulators cleared. All outputs 0 except stable=1.
- FSM states: IDLE, SORT, DIST, CMP, DONE.
- IDLE:
  - start=1 latches mode, enables, returned, axis and all three operands.
  - Next state is SORT if mode=0, else DIST with dimension counter=0.
  - start while busy=1 is ignored. Inputs may change freely after acceptance.
- SORT (1 cycle), key = coordinate [axis]:
  - Both enables set: new_left/new_parent/new_right = ascending min/median/max of (left,parent,right).
  - Only left_en: 2-sort of left/parent; new_right=right.
  - Only right_en: 2-sort of parent/right; new_left=left.
  - Neither enable: pass-through.
  - Equal keys never swap; the original relative order is kept.
  - x_switch=1 iff slot x now holds a different source operand. stable = no switch.
  - Next state: DONE.
- DIST (DIM cycles):
  - Cycle k adds |q_k-c_k| to dist_node and |q_k-b_k| to dist_best.
  - Counter wraps to 0 on leaving. Next state: CMP.
- CMP (1 cycle):
  - If dist_node<dist_best: new_parent=node centre, best_dist=dist_node. Otherwise new_parent=best centre, best_dist=dist_best. A tie keeps the old best.
  - new_left=query (forwarded to child). new_right=0.
  - first_direction = q[axis] < c[axis].
  - other_branch = returned && (|q[axis]-c[axis]| < best_dist new value); 0 when returned=0.
  - Sort flags hold their previous values. Next state: DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start in the DONE cycle is not accepted.
- Latency from start edge to done: sort = 2 cycles, search = DIM+2 cycles.
- Outputs hold their values until the next operation's result cycle.
- rst asserted mid-operation: immediate return to IDLE, no done pulse, outputs at reset values.

Test Plan:
1. DIM=3, DATA_W=8, sort, axis=0, both en, left.x=50, parent.x=30, right.x=10 -> done 2 cycles after start; new_left.x=10, new_parent.x=30, new_right.x=50; left_switch=1, parent_switch=0, right_switch=1, stable=0.
2. Sort, only left_en, left.x=parent.x=20 -> no swap, stable=1, all switches 0. Repeat with left.x=40, parent.x=20 -> swapped, left_switch=parent_switch=1.
3. Search, axis=0, returned=1, q=(10,20,30), c=(12,18,30), b=(10,20,40):
   - done 5 cycles after start.
   - best_dist=4, new_parent=c, new_left=q, new_right=0.
   - first_direction=1, other_branch=1 (2<4).
   - Same with returned=0 -> other_branch=0.
4. Search tie: c and b both at distance 6 from q -> new_parent=b, best_dist=6. Extremes q=(0,0,0), c=(255,255,255), b=c -> best_dist=765 with no overflow.
5. Handshake: start held high for 10 cycles in search mode -> exactly two operations, each done a single-cycle pulse, busy high between. axis=3 behaves as axis=0.
6. Assert rst on cycle 2 of DIST -> busy=0 and outputs zeroed immediately, no done; a fresh start after release produces correct results.

Source files
------------

// File: rtl/kd_node_ce.sv
// Sequential compare-exchange / nearest-centre element for one kd-tree node.
// Sort mode orders three centres along an axis; search mode accumulates Manhattan distances.
module kd_node_ce #(
    parameter int    DIM    = 3,
    parameter int    DATA_W = 8,
    parameter int    AXIS_W = (DIM > 1) ? $clog2(DIM) : 1,
    parameter int    DIST_W = DATA_W + $clog2(DIM),
    parameter string name   = "unknown"
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic                    left_en,
    input  logic                    right_en,
    input  logic                    returned,
    input  logic [AXIS_W-1:0]       axis,
    input  logic [DIM*DATA_W-1:0]   left,
    input  logic [DIM*DATA_W-1:0]   parent,
    input  logic [DIM*DATA_W-1:0]   right,
    output logic                    busy,
    output logic                    done,
    output logic                    stable,
    output logic                    left_switch,
    output logic                    parent_switch,
    output logic                    right_switch,
    output logic                    first_direction,
    output logic                    other_branch,
    output logic [DIM*DATA_W-1:0]   new_left,
    output logic [DIM*DATA_W-1:0]   new_parent,
    output logic [DIM*DATA_W-1:0]   new_right,
    output logic [DIST_W-1:0]       best_dist
);
    localparam int W = DIM * DATA_W;

    typedef enum logic [2:0] {S_IDLE, S_SORT, S_DIST, S_CMP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [AXIS_W-1:0]   cnt_q, cnt_d, axis_q, axis_d;
    logic                le_q, le_d, re_q, re_d, ret_q, ret_d;
    logic [W-1:0]        opl_q, opl_d, opp_q, opp_d, opr_q, opr_d;
    logic [DIST_W-1:0]   dn_q, dn_d, db_q, db_d, bd_q, bd_d;
    logic                st_q, st_d, ls_q, ls_d, ps_q, ps_d, rs_q, rs_d;
    logic                fd_q, fd_d, ob_q, ob_d;
    logic [W-1:0]        nl_q, nl_d, np_q, np_d, nr_q, nr_d;

    function automatic logic [DATA_W-1:0] coord(input logic [W-1:0] v, input logic [AXIS_W-1:0] i);
        return v[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] absdiff(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // Stable bubble network; strict '>' means equal keys never swap.
    logic [W-1:0] s0, s1, s2, tv;
    logic [1:0]   i0, i1, i2, ti;
    always_comb begin
        s0 = opl_q;
        s1 = opp_q;
        s2 = opr_q;
        i0 = 2'd0;
        i1 = 2'd1;
        i2 = 2'd2;
        tv = '0;
        ti = 2'd0;
        if (le_q && (coord(s0, axis_q) > coord(s1, axis_q))) begin
            tv = s0; s0 = s1; s1 = tv;
            ti = i0; i0 = i1; i1 = ti;
        end
        if (re_q && (coord(s1, axis_q) > coord(s2, axis_q))) begin
            tv = s1; s1 = s2; s2 = tv;
            ti = i1; i1 = i2; i2 = ti;
        end
        if (le_q && re_q && (coord(s0, axis_q) > coord(s1, axis_q))) begin
            tv = s0; s0 = s1; s1 = tv;
            ti = i0; i0 = i1; i1 = ti;
        end
    end

    logic [DIST_W-1:0] bd_new;
    logic [DATA_W-1:0] q_ax, c_ax;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        axis_d  = axis_q;
        le_d    = le_q;
        re_d    = re_q;
        ret_d   = ret_q;
        opl_d   = opl_q;
        opp_d   = opp_q;
        opr_d   = opr_q;
        dn_d    = dn_q;
        db_d    = db_q;
        bd_d    = bd_q;
        st_d    = st_q;
        ls_d    = ls_q;
        ps_d    = ps_q;
        rs_d    = rs_q;
        fd_d    = fd_q;
        ob_d    = ob_q;
        nl_d    = nl_q;
        np_d    = np_q;
        nr_d    = nr_q;
        bd_new  = '0;
        q_ax    = coord(opl_q, axis_q);
        c_ax    = coord(opp_q, axis_q);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    le_d    = left_en;
                    re_d    = right_en;
                    ret_d   = returned;
                    axis_d  = (int'(axis) >= DIM) ? '0 : axis;
                    opl_d   = left;
                    opp_d   = parent;
                    opr_d   = right;
                    cnt_d   = '0;
                    dn_d    = '0;
                    db_d    = '0;
                    state_d = mode ? S_DIST : S_SORT;
                end
            end
            S_SORT: begin
                nl_d    = s0;
                np_d    = s1;
                nr_d    = s2;
                ls_d    = (i0 != 2'd0);
                ps_d    = (i1 != 2'd1);
                rs_d    = (i2 != 2'd2);
                st_d    = (i0 == 2'd0) && (i1 == 2'd1) && (i2 == 2'd2);
                state_d = S_DONE;
            end
            S_DIST: begin
                dn_d = dn_q + DIST_W'(absdiff(coord(opl_q, cnt_q), coord(opp_q, cnt_q)));
                db_d = db_q + DIST_W'(absdiff(coord(opl_q, cnt_q), coord(opr_q, cnt_q)));
                if (int'(cnt_q) == DIM - 1) begin
                    cnt_d   = '0;
                    state_d = S_CMP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CMP: begin
                // A tie keeps the incumbent best centre.
                if (dn_q < db_q) begin
                    np_d   = opp_q;
                    bd_new = dn_q;
                end else begin
                    np_d   = opr_q;
                    bd_new = db_q;
                end
                bd_d    = bd_new;
                nl_d    = opl_q;
                nr_d    = '0;
                fd_d    = q_ax < c_ax;
                ob_d    = ret_q && (DIST_W'(absdiff(q_ax, c_ax)) < bd_new);
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            axis_q  <= '0;
            le_q    <= 1'b0;
            re_q    <= 1'b0;
            ret_q   <= 1'b0;
            opl_q   <= '0;
            opp_q   <= '0;
            opr_q   <= '0;
            dn_q    <= '0;
            db_q    <= '0;
            bd_q    <= '0;
            st_q    <= 1'b1;
            ls_q    <= 1'b0;
            ps_q    <= 1'b0;
            rs_q    <= 1'b0;
            fd_q    <= 1'b0;
            ob_q    <= 1'b0;
            nl_q    <= '0;
            np_q    <= '0;
            nr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            axis_q  <= axis_d;
            le_q    <= le_d;
            re_q    <= re_d;
            ret_q   <= ret_d;
            opl_q   <= opl_d;
            opp_q   <= opp_d;
            opr_q   <= opr_d;
            dn_q    <= dn_d;
            db_q    <= db_d;
            bd_q    <= bd_d;
            st_q    <= st_d;
            ls_q    <= ls_d;
            ps_q    <= ps_d;
            rs_q    <= rs_d;
            fd_q    <= fd_d;
            ob_q    <= ob_d;
            nl_q    <= nl_d;
            np_q    <= np_d;
            nr_q    <= nr_d;
        end
    end

    assign busy            = (state_q == S_SORT) || (state_q == S_DIST) || (state_q == S_CMP);
    assign done            = (state_q == S_DONE);
    assign stable          = st_q;
    assign left_switch     = ls_q;
    assign parent_switch   = ps_q;
    assign right_switch    = rs_q;
    assign first_direction = fd_q;
    assign other_branch    = ob_q;
    assign new_left        = nl_q;
    assign new_parent      = np_q;
    assign new_right       = nr_q;
    assign best_dist       = bd_q;
endmodule

// File: tb/tb_kd_node_ce.sv
// Scoreboard bench for kd_node_ce (DIM=3, DATA_W=8): directed vectors, done-triggered monitor.
module tb_kd_node_ce;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0, left_en = 1'b0, right_en = 1'b0, returned = 1'b0;
    logic [1:0]  axis = 2'd0;
    logic [23:0] left = '0, parent = '0, right = '0;
    logic        busy, done, stable, left_switch, parent_switch, right_switch;
    logic        first_direction, other_branch;
    logic [23:0] new_left, new_parent, new_right;
    logic [9:0]  best_dist;

    kd_node_ce #(.DIM(3), .DATA_W(8), .name("ce0")) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .left_en(left_en),
        .right_en(right_en), .returned(returned), .axis(axis), .left(left),
        .parent(parent), .right(right), .busy(busy), .done(done), .stable(stable),
        .left_switch(left_switch), .parent_switch(parent_switch),
        .right_switch(right_switch), .first_direction(first_direction),
        .other_branch(other_branch), .new_left(new_left), .new_parent(new_parent),
        .new_right(new_right), .best_dist(best_dist)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        st, ls, ps, rs, fd, ob;
        logic [23:0] nl, np, nr;
        logic [9:0]  bd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic       sh_st = 1'b1, sh_ls = 1'b0, sh_ps = 1'b0, sh_rs = 1'b0;
    logic       sh_fd = 1'b0, sh_ob = 1'b0;
    logic [9:0] sh_bd = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endfunction

    function automatic logic [23:0] pk(int x, int y, int z);
        return {8'(z), 8'(y), 8'(x)};
    endfunction

    function automatic exp_t mk_sort(logic [23:0] nl, logic [23:0] np, logic [23:0] nr,
                                     logic st, logic ls, logic ps, logic rs);
        exp_t e;
        e.nl = nl; e.np = np; e.nr = nr;
        e.st = st; e.ls = ls; e.ps = ps; e.rs = rs;
        e.bd = sh_bd; e.fd = sh_fd; e.ob = sh_ob; e.cyc = 0;
        sh_st = st; sh_ls = ls; sh_ps = ps; sh_rs = rs;
        return e;
    endfunction

    function automatic exp_t mk_search(logic [23:0] q, logic [23:0] np, int bd,
                                       logic fd, logic ob);
        exp_t e;
        e.nl = q; e.np = np; e.nr = '0;
        e.st = sh_st; e.ls = sh_ls; e.ps = sh_ps; e.rs = sh_rs;
        e.bd = 10'(bd); e.fd = fd; e.ob = ob; e.cyc = 0;
        sh_bd = 10'(bd); sh_fd = fd; sh_ob = ob;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 required no pending operation (cyc=%0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", busy, 0);
                chk("new_left", new_left, e.nl);
                chk("new_parent", new_parent, e.np);
                chk("new_right", new_right, e.nr);
                chk("best_dist", best_dist, e.bd);
                chk("stable", stable, e.st);
                chk("left_switch", left_switch, e.ls);
                chk("parent_switch", parent_switch, e.ps);
                chk("right_switch", right_switch, e.rs);
                chk("first_direction", first_direction, e.fd);
                chk("other_branch", other_branch, e.ob);
            end
        end
    end

    task automatic drain(string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout_%s: got %0d pending results required 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic issue(logic m, logic le, logic re, logic ret, logic [1:0] ax,
                         logic [23:0] l, logic [23:0] p, logic [23:0] r, exp_t e, string nm);
        @(negedge clk);
        mode = m; left_en = le; right_en = re; returned = ret; axis = ax;
        left = l; parent = p; right = r; start = 1'b1;
        e.cyc = cyc + (m ? 5 : 2);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        left = 24'($urandom); parent = 24'($urandom); right = 24'($urandom);
        axis = 2'($urandom); left_en = ~le; right_en = ~re; returned = ~ret; mode = ~m;
        drain(nm);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_stable"}, stable, 1);
        chk({tag, "_switches"}, {left_switch, parent_switch, right_switch}, 0);
        chk({tag, "_dir_branch"}, {first_direction, other_branch}, 0);
        chk({tag, "_new_left"}, new_left, 0);
        chk({tag, "_new_parent"}, new_parent, 0);
        chk({tag, "_new_right"}, new_right, 0);
        chk({tag, "_best_dist"}, best_dist, 0);
    endtask

    initial begin
        logic [23:0] q3, c3, b3;
        exp_t e;
        int c;
        q3 = pk(10, 20, 30); c3 = pk(12, 18, 30); b3 = pk(10, 20, 40);

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Sort: three-way ascending
        e = mk_sort(pk(10, 5, 6), pk(30, 3, 4), pk(50, 1, 2), 0, 1, 0, 1);
        issue(0, 1, 1, 0, 0, pk(50, 1, 2), pk(30, 3, 4), pk(10, 5, 6), e, "sort3");
        // Only left_en: equal keys, then swap
        e = mk_sort(pk(20, 9, 9), pk(20, 8, 8), pk(77, 0, 0), 1, 0, 0, 0);
        issue(0, 1, 0, 0, 0, pk(20, 9, 9), pk(20, 8, 8), pk(77, 0, 0), e, "sort_l_eq");
        e = mk_sort(pk(20, 8, 8), pk(40, 9, 9), pk(77, 0, 0), 0, 1, 1, 0);
        issue(0, 1, 0, 0, 0, pk(40, 9, 9), pk(20, 8, 8), pk(77, 0, 0), e, "sort_l_swap");
        // Only right_en on axis 1
        e = mk_sort(pk(7, 7, 7), pk(0, 5, 0), pk(0, 90, 0), 0, 0, 1, 1);
        issue(0, 0, 1, 0, 1, pk(7, 7, 7), pk(0, 90, 0), pk(0, 5, 0), e, "sort_r");
        // Neither enable: pass-through of unordered data
        e = mk_sort(pk(9, 0, 0), pk(5, 0, 0), pk(1, 0, 0), 1, 0, 0, 0);
        issue(0, 0, 0, 0, 0, pk(9, 0, 0), pk(5, 0, 0), pk(1, 0, 0), e, "sort_none");
        // Both with a tie between left and parent
        e = mk_sort(pk(2, 1, 2), pk(0, 5, 0), pk(1, 5, 1), 0, 1, 1, 1);
        issue(0, 1, 1, 0, 1, pk(0, 5, 0), pk(1, 5, 1), pk(2, 1, 2), e, "sort_tie");

        // Search
        e = mk_search(q3, c3, 4, 1, 1);
        issue(1, 0, 0, 1, 0, q3, c3, b3, e, "search_ret1");
        e = mk_search(q3, c3, 4, 1, 0);
        issue(1, 0, 0, 0, 0, q3, c3, b3, e, "search_ret0");
        e = mk_search(pk(0, 0, 0), pk(3, 3, 0), 6, 1, 1);
        issue(1, 0, 0, 1, 0, pk(0, 0, 0), pk(1, 2, 3), pk(3, 3, 0), e, "search_tie");
        e = mk_search(pk(0, 0, 0), pk(255, 255, 255), 765, 1, 0);
        issue(1, 0, 0, 0, 0, pk(0, 0, 0), pk(255, 255, 255), pk(255, 255, 255), e, "search_max");
        e = mk_search(pk(100, 100, 100), pk(90, 100, 110), 20, 0, 0);
        issue(1, 0, 0, 1, 2, pk(100, 100, 100), pk(0, 0, 0), pk(90, 100, 110), e, "search_best");
        e = mk_search(pk(5, 5, 5), pk(5, 8, 5), 3, 1, 0);
        issue(1, 0, 0, 1, 1, pk(5, 5, 5), pk(5, 8, 5), pk(0, 0, 0), e, "search_prune_eq");

        // Start held for 10 cycles, axis=3 clamps to axis 0
        @(negedge clk);
        mode = 1; returned = 1; axis = 2'd3; left = q3; parent = c3; right = b3; start = 1'b1;
        c = cyc;
        e = mk_search(q3, c3, 4, 1, 1); e.cyc = c + 5;  exp_q.push_back(e);
        e = mk_search(q3, c3, 4, 1, 1); e.cyc = c + 11; exp_q.push_back(e);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("held_busy_k%0d", k), busy, ((k >= 1 && k <= 4) || k >= 7) ? 1 : 0);
            @(negedge clk);
        end
        start = 1'b0;
        drain("held_start");

        // Sort after search keeps search outputs
        e = mk_sort(pk(0, 0, 1), pk(0, 0, 2), pk(0, 0, 3), 0, 1, 0, 1);
        issue(0, 1, 1, 0, 2, pk(0, 0, 3), pk(0, 0, 2), pk(0, 0, 1), e, "sort_after_search");

        // Reset during DIST
        @(negedge clk);
        mode = 1; returned = 1; axis = 0; left = q3; parent = c3; right = b3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        sh_st = 1; sh_ls = 0; sh_ps = 0; sh_rs = 0; sh_fd = 0; sh_ob = 0; sh_bd = '0;
        repeat (8) @(negedge clk);
        e = mk_search(q3, c3, 4, 1, 1);
        issue(1, 0, 0, 1, 0, q3, c3, b3, e, "after_reset");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
